// File: rtl/cyclotron_lsu_mem.sv
// cyclotron_lsu_mem: LSU-side vector memory model.
// One vector request per cycle is accepted. Each lane does a word load or store
// against a local array in the cycle it is accepted. The response then moves
// through LATENCY-1 register stages into a response FIFO. A credit count of
// outstanding responses gates req_ready, so the FIFO can never overflow.
module cyclotron_lsu_mem #(
    parameter int ARCH_LEN    = 32,
    parameter int LSU_LANES   = 16,
    parameter int TAG_BITS    = 32,
    parameter int MEM_WORDS   = 4096,
    parameter int LATENCY     = 2,
    parameter int QUEUE_DEPTH = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    output logic                          req_ready,
    input  logic                          req_valid,
    input  logic                          req_store,
    input  logic [LSU_LANES*ARCH_LEN-1:0] req_address,
    input  logic [TAG_BITS-1:0]           req_tag,
    input  logic [LSU_LANES*ARCH_LEN-1:0] req_data,
    input  logic [LSU_LANES-1:0]          req_mask,
    input  logic                          resp_ready,
    output logic                          resp_valid,
    output logic [TAG_BITS-1:0]           resp_tag,
    output logic [LSU_LANES*ARCH_LEN-1:0] resp_data,
    output logic [LSU_LANES-1:0]          resp_valids,
    output logic [LSU_LANES-1:0]          resp_oob,
    output logic                          busy
);

    localparam int AW   = $clog2(MEM_WORDS);
    localparam int NSTG = LATENCY - 1;
    localparam int SW   = (NSTG > 0) ? NSTG : 1;
    localparam int QW   = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int CW   = $clog2(QUEUE_DEPTH + 1);
    localparam logic [QW-1:0] QLAST = QW'(QUEUE_DEPTH - 1);

    typedef struct packed {
        logic [TAG_BITS-1:0]           tag;
        logic [LSU_LANES*ARCH_LEN-1:0] data;
        logic [LSU_LANES-1:0]          valids;
        logic [LSU_LANES-1:0]          oob;
    } entry_t;

    // The array is not reset; stores made before a reset survive it.
    logic [ARCH_LEN-1:0] mem_q [MEM_WORDS];

    logic                accept;
    logic                deq;
    entry_t              acc_e;
    logic [ARCH_LEN-1:0] lane_addr [LSU_LANES];
    logic [AW-1:0]       lane_idx  [LSU_LANES];
    logic [LSU_LANES-1:0] lane_oob;

    entry_t        stg_e_q [SW];
    entry_t        stg_e_d [SW];
    logic [SW-1:0] stg_v_q, stg_v_d;
    logic          fin_v;
    entry_t        fin_e;

    entry_t        fifo_q [QUEUE_DEPTH];
    entry_t        head;
    logic [QW-1:0] wr_ptr_q, wr_ptr_d;
    logic [QW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] fcnt_q, fcnt_d;
    logic [CW-1:0] out_q, out_d;

    // The credit check looks only at the registered count. A dequeue in the
    // same cycle therefore does not raise req_ready until the next cycle.
    assign req_ready  = reset && (out_q < CW'(QUEUE_DEPTH));
    assign accept     = req_valid && req_ready;
    assign resp_valid = reset && (fcnt_q != '0);
    assign deq        = resp_valid && resp_ready;
    assign busy       = reset && (out_q != '0);

    assign head        = fifo_q[rd_ptr_q];
    assign resp_tag    = resp_valid ? head.tag    : '0;
    assign resp_data   = resp_valid ? head.data   : '0;
    assign resp_valids = resp_valid ? head.valids : '0;
    assign resp_oob    = resp_valid ? head.oob    : '0;

    // Per-lane address decode and load sampling for the request being offered.
    // Address bits [1:0] are ignored. A lane is out of range if any bit above
    // the word index is set.
    always_comb begin
        acc_e        = '0;
        lane_oob     = '0;
        acc_e.tag    = req_tag;
        acc_e.valids = req_mask;
        for (int i = 0; i < LSU_LANES; i++) begin
            lane_addr[i] = req_address[i*ARCH_LEN +: ARCH_LEN];
            lane_idx[i]  = lane_addr[i][AW+1:2];
            lane_oob[i]  = (lane_addr[i] >> (AW + 2)) != '0;
            if (req_mask[i] && lane_oob[i]) begin
                acc_e.oob[i] = 1'b1;
            end
            if (!req_store && req_mask[i] && !lane_oob[i]) begin
                acc_e.data[i*ARCH_LEN +: ARCH_LEN] = mem_q[lane_idx[i]];
            end
        end
    end

    // Store lanes at the accept edge. Lanes are visited in ascending order, so
    // when several lanes hit the same word the last write, from the highest
    // lane, wins.
    always_ff @(posedge clock) begin
        if (accept && req_store) begin
            for (int i = 0; i < LSU_LANES; i++) begin
                if (req_mask[i] && !lane_oob[i]) begin
                    mem_q[lane_idx[i]] <= req_data[i*ARCH_LEN +: ARCH_LEN];
                end
            end
        end
    end

    // Latency pipeline. With LATENCY == 1 the accepted entry goes straight
    // into the FIFO.
    always_comb begin
        stg_v_d    = stg_v_q;
        stg_v_d[0] = accept;
        stg_e_d[0] = acc_e;
        for (int s = 1; s < SW; s++) begin
            stg_v_d[s] = stg_v_q[s-1];
            stg_e_d[s] = stg_e_q[s-1];
        end
        if (NSTG == 0) begin
            fin_v = accept;
            fin_e = acc_e;
        end else begin
            fin_v = stg_v_q[SW-1];
            fin_e = stg_e_q[SW-1];
        end
    end

    // Next state for the FIFO pointers, the FIFO occupancy and the credit count.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        fcnt_d   = fcnt_q;
        out_d    = out_q;
        if (fin_v) begin
            wr_ptr_d = (wr_ptr_q == QLAST) ? '0 : wr_ptr_q + 1'b1;
        end
        if (deq) begin
            rd_ptr_d = (rd_ptr_q == QLAST) ? '0 : rd_ptr_q + 1'b1;
        end
        case ({fin_v, deq})
            2'b10:   fcnt_d = fcnt_q + 1'b1;
            2'b01:   fcnt_d = fcnt_q - 1'b1;
            default: fcnt_d = fcnt_q;
        endcase
        case ({accept, deq})
            2'b10:   out_d = out_q + 1'b1;
            2'b01:   out_d = out_q - 1'b1;
            default: out_d = out_q;
        endcase
    end

    // Control state. A reset drops every in-flight response.
    always_ff @(posedge clock) begin
        if (!reset) begin
            stg_v_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fcnt_q   <= '0;
            out_q    <= '0;
        end else begin
            stg_v_q  <= stg_v_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            fcnt_q   <= fcnt_d;
            out_q    <= out_d;
        end
    end

    // Payload storage. No reset is needed here because the valid bits and the
    // FIFO pointers decide what is visible.
    always_ff @(posedge clock) begin
        stg_e_q <= stg_e_d;
        if (fin_v) begin
            fifo_q[wr_ptr_q] <= fin_e;
        end
    end

endmodule

// File: tb/tb_cyclotron_lsu_mem.sv
// Bench for cyclotron_lsu_mem using LSU_LANES=4, MEM_WORDS=256, LATENCY=2 and
// QUEUE_DEPTH=4. A reference model holds a word array and a queue of expected
// responses, each tagged with the cycle from which it may appear. The DUT is
// compared against this model every cycle.
module tb_cyclotron_lsu_mem;

    localparam int LANES = 4;
    localparam int MW    = 256;
    localparam int LAT   = 2;
    localparam int QD    = 4;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         req_ready, req_valid, req_store;
    logic [127:0] req_address, req_data;
    logic [31:0]  req_tag;
    logic [3:0]   req_mask;
    logic         resp_ready;
    logic         resp_valid;
    logic [31:0]  resp_tag;
    logic [127:0] resp_data;
    logic [3:0]   resp_valids, resp_oob;
    logic         busy;

    cyclotron_lsu_mem #(
        .ARCH_LEN(32), .LSU_LANES(LANES), .TAG_BITS(32),
        .MEM_WORDS(MW), .LATENCY(LAT), .QUEUE_DEPTH(QD)
    ) dut (
        .clock(clock), .reset(reset),
        .req_ready(req_ready), .req_valid(req_valid), .req_store(req_store),
        .req_address(req_address), .req_tag(req_tag), .req_data(req_data),
        .req_mask(req_mask), .resp_ready(resp_ready), .resp_valid(resp_valid),
        .resp_tag(resp_tag), .resp_data(resp_data), .resp_valids(resp_valids),
        .resp_oob(resp_oob), .busy(busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0]  tag;
        logic [127:0] data;
        logic [3:0]   valids;
        logic [3:0]   oob;
        int           due;
    } rsp_t;

    int           nchk = 0;
    int           nerr = 0;
    int           cyc  = 0;
    int           n_acc_obs;
    logic [31:0]  mm [MW];
    rsp_t         q [$];
    logic [127:0] got_data   [int];
    logic [3:0]   got_valids [int];
    logic [3:0]   got_oob    [int];
    logic [31:0]  deq_tags [$];

    task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] pack4(input logic [31:0] a, input logic [31:0] b,
                                           input logic [31:0] c, input logic [31:0] d);
        return {d, c, b, a};
    endfunction

    task automatic set_req(input logic st, input logic [127:0] addr, input logic [127:0] data,
                           input logic [3:0] mask, input logic [31:0] tag);
        req_valid   = 1'b1;
        req_store   = st;
        req_address = addr;
        req_data    = data;
        req_mask    = mask;
        req_tag     = tag;
    endtask

    // One clock: compare the outputs on the falling edge, advance the model,
    // then return just after the rising edge so the caller can drive new inputs.
    task automatic cycle();
        logic        exp_ready, exp_valid, acc, oob;
        rsp_t        r;
        logic [31:0] a;
        @(negedge clock);
        exp_ready = reset && (q.size() < QD);
        exp_valid = reset && (q.size() != 0) && (q[0].due <= cyc);
        check("req_ready", req_ready, exp_ready);
        check("resp_valid", resp_valid, exp_valid);
        check("busy", busy, reset && (q.size() != 0));
        if (exp_valid && resp_valid) begin
            check("resp_tag", resp_tag, q[0].tag);
            check("resp_data", resp_data, q[0].data);
            check("resp_valids", resp_valids, q[0].valids);
            check("resp_oob", resp_oob, q[0].oob);
        end else if (!reset) begin
            check("reset outputs", {resp_tag, resp_data, resp_valids, resp_oob}, '0);
        end
        if (req_valid && req_ready) n_acc_obs++;
        acc = req_valid && exp_ready;
        if (exp_valid && resp_ready) begin
            got_data[q[0].tag]   = resp_data;
            got_valids[q[0].tag] = resp_valids;
            got_oob[q[0].tag]    = resp_oob;
            deq_tags.push_back(resp_tag);
            void'(q.pop_front());
        end
        if (acc) begin
            r.tag = req_tag; r.valids = req_mask; r.oob = '0; r.data = '0; r.due = cyc + LAT;
            for (int i = 0; i < LANES; i++) begin
                a   = req_address[i*32 +: 32];
                oob = (a / 4) >= MW;
                if (req_mask[i] && oob) r.oob[i] = 1'b1;
                if (!req_store && req_mask[i] && !oob) r.data[i*32 +: 32] = mm[a / 4];
            end
            if (req_store) begin
                for (int i = 0; i < LANES; i++) begin
                    a = req_address[i*32 +: 32];
                    if (req_mask[i] && (a / 4) < MW) mm[a / 4] = req_data[i*32 +: 32];
                end
            end
            q.push_back(r);
        end
        if (!reset) q.delete();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic drain();
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        for (int i = 0; i < 50 && q.size() != 0; i++) cycle();
        check("drain bound", q.size(), 0);
    endtask

    initial begin
        logic [127:0] ad, dd;
        logic [31:0]  w;
        int           k;
        req_valid = 0; req_store = 0; req_address = '0; req_data = '0;
        req_tag = '0; req_mask = '0; resp_ready = 1'b1; n_acc_obs = 0;
        for (int i = 0; i < MW; i++) mm[i] = '0;

        // Hold reset, then release.
        cycle(); cycle();
        reset = 1'b1;
        cycle();

        // Give every word a known value.
        for (int wd = 0; wd < MW / 4; wd++) begin
            set_req(1'b1, pack4(16*wd, 16*wd+4, 16*wd+8, 16*wd+12),
                    {$urandom(), $urandom(), $urandom(), $urandom()}, 4'hF, 1000 + wd);
            cycle();
        end
        drain();

        // Store followed directly by a load of the same words.
        set_req(1'b1, pack4(0, 4, 8, 12), pack4(32'h11, 32'h22, 32'h33, 32'h44), 4'hF, 5);
        cycle();
        set_req(1'b0, pack4(0, 4, 8, 12), '0, 4'hF, 6);
        cycle();
        drain();
        check("store resp data", got_data[5], 0);
        check("store resp valids", got_valids[5], 4'hF);
        check("load after store", got_data[6], pack4(32'h11, 32'h22, 32'h33, 32'h44));

        // Partial-mask load.
        set_req(1'b0, pack4(0, 4, 8, 12), '0, 4'h5, 7);
        cycle();
        drain();
        check("mask5 valids", got_valids[7], 4'h5);
        check("mask5 data", got_data[7], pack4(32'h11, 0, 32'h33, 0));

        // Two lanes store to one word; the higher lane must win.
        set_req(1'b1, pack4(32'h40, 32'h44, 32'h40, 32'h48), pack4(32'hAA, 1, 32'hBB, 2), 4'h5, 8);
        cycle();
        set_req(1'b0, pack4(32'h40, 0, 0, 0), '0, 4'h1, 9);
        cycle();
        drain();
        w = got_data[9][31:0];
        check("conflict winner", w, 32'hBB);

        // Out-of-range lane.
        set_req(1'b1, pack4(0, 32'h400, 0, 0), pack4(0, 32'hDEAD, 0, 0), 4'h2, 10);
        cycle();
        set_req(1'b0, pack4(0, 32'h400, 0, 0), '0, 4'h3, 11);
        cycle();
        drain();
        check("oob store flag", got_oob[10], 4'h2);
        check("oob load flag", got_oob[11], 4'h2);
        check("oob load data", got_data[11], pack4(32'h11, 0, 0, 0));

        // Backpressure: the queue fills after 4 requests and ready drops.
        resp_ready = 1'b0;
        n_acc_obs  = 0;
        deq_tags.delete();
        for (int t = 1; t <= 6; t++) begin
            set_req(1'b0, pack4(0, 4, 8, 12), '0, 4'hF, t);
            cycle();
        end
        check("full accepts", n_acc_obs, 4);
        req_valid = 1'b0;
        cycle(); cycle();
        resp_ready = 1'b1;
        for (int t = 5; t <= 6; t++) begin
            set_req(1'b0, pack4(0, 4, 8, 12), '0, 4'hF, t);
            k = 0;
            n_acc_obs = 0;
            while (n_acc_obs == 0 && k < 20) begin
                cycle();
                k++;
            end
            check("retry accepted", n_acc_obs, 1);
        end
        drain();
        check("deq count", deq_tags.size(), 6);
        for (int t = 0; t < 6 && t < deq_tags.size(); t++) check("deq order", deq_tags[t], t + 1);

        // Reset with requests in flight; the array keeps its contents.
        set_req(1'b1, pack4(32'h80, 0, 0, 0), pack4(32'h77, 0, 0, 0), 4'h1, 30);
        cycle();
        drain();
        resp_ready = 1'b0;
        set_req(1'b0, pack4(0, 4, 8, 12), '0, 4'hF, 31);
        cycle();
        set_req(1'b0, pack4(0, 4, 8, 12), '0, 4'hF, 32);
        cycle();
        req_valid = 1'b0;
        reset = 1'b0;
        cycle();
        reset = 1'b1;
        resp_ready = 1'b1;
        cycle(); cycle(); cycle();
        set_req(1'b0, pack4(32'h80, 0, 0, 0), '0, 4'h1, 33);
        cycle();
        drain();
        w = got_data[33][31:0];
        check("store survives reset", w, 32'h77);

        // Random traffic with random backpressure.
        for (int n = 0; n < 400; n++) begin
            resp_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 2) != 0) begin
                for (int i = 0; i < LANES; i++) begin
                    ad[i*32 +: 32] = ($urandom_range(0, 7) == 0) ? ($urandom() | 32'h400)
                                                                 : 32'($urandom_range(0, 255));
                    dd[i*32 +: 32] = $urandom();
                end
                set_req(1'($urandom_range(0, 1)), ad, dd, 4'($urandom_range(0, 15)), $urandom());
            end else begin
                req_valid = 1'b0;
            end
            cycle();
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
        $finish;
    end

endmodule
